spram_banked: RTL and testbench
===============================

// Module: spram_banked
// PURPOSE
//  Parametrised successor to the single-bank 16K x 16 SPRAM wrapper. Tiles 1, 2 or 4
//  SB_SPRAM256KA banks into one 16-bit word space, for up to 64K words on UP5K.
//  Adds a valid/ready request port, nibble write masks and a tagged read response.
//  Adds an idle-driven SLEEP/WAKE power state machine. Serves as CPU data/ROM store.
// PARAMETERS
//  BANKS        1  number of SPRAM banks; legal values 1, 2 or 4
//  ADDR_W       14+$clog2(BANKS)  word-address width (derived, not overridden)
//  IDLE_CYCLES  0  idle cycles in ACTIVE before entering SLEEP; 0 = never sleep
//  WAKE_CYCLES  3  cycles held in WAKE after SLEEP deasserts, before ready returns
// PORTS
//  clk        in   1       single clock; all state on rising edge
//  rst_n      in   1       asynchronous reset, active-low
//  req_valid  in   1       request present
//  req_ready  out  1       request accepted when req_valid & req_ready
//  req_we     in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  word address; top $clog2(BANKS) bits select the bank
//  req_wdata  in   16      write data
//  req_mask   in   4       nibble write enable; bit i gates wdata[4i+3:4i]
//  rsp_valid  out  1       one-cycle pulse: rsp_rdata is valid for an accepted read
//  rsp_rdata  out  16      read data; holds its value until the next response
//  sleeping   out  1       1 while the banks are in SLEEP or WAKE
// BEHAVIOUR
//  Reset values: state=ACTIVE, req_ready=1, rsp_valid=0, rsp_rdata=0, sleeping=0,
//   idle/wake counters=0. Reset does not alter RAM contents.
//  Per-bank SPRAM pin tie-offs:
//   - POWEROFF tied to 1 (powered); STANDBY tied to 0.
//   - SLEEP is driven from the FSM.
//  Per-bank SPRAM pin drive on an accepted request:
//   - CHIPSELECT=1 only for the selected bank.
//   - WREN=req_we; MASKWREN=req_mask; DATAIN=req_wdata.
//   - ADDRESS=req_addr[13:0].
//  Write: takes effect at the accepting edge. No response is generated.
//  Read latency: rsp_valid rises 1 cycle after acceptance.
//   - rsp_rdata is muxed by the bank index registered at acceptance.
//  Throughput: one request per cycle in ACTIVE.
//   - Back-to-back reads give back-to-back rsp_valid.
//   - A write is allowed in the cycle after a read; the read response is unaffected.
//  FSM:
//   ACTIVE -> SLEEP when IDLE_CYCLES!=0 and idle count reaches IDLE_CYCLES.
//      - Idle count increments on each cycle with no accepted request.
//      - Idle count clears on acceptance.
//      - A pending read response still completes before SLEEP asserts.
//   SLEEP  -> WAKE on req_valid=1.
//      - req_ready=0 and SLEEP=1 on all banks.
//   WAKE   -> ACTIVE after WAKE_CYCLES cycles.
//      - SLEEP=0 and req_ready=0 during WAKE.
//      - The requester keeps req_valid asserted; it is accepted in the first ACTIVE cycle.
//  sleeping=1 in SLEEP and WAKE. RAM contents are retained through SLEEP.
//  Out-of-range address bits do not exist (ADDR_W is exact); BANKS=1 has no bank mux.
//  Reset mid-read: the pending response is discarded and rsp_valid stays 0.
// CONFIGURATION
//  SPRAM_OUTREG_EN defined: extra output register after the bank mux.
//   - Read latency becomes 2 cycles.
//   - rsp_valid and rsp_rdata come directly from flops; throughput unchanged.
//  SPRAM_OUTREG_EN undefined: read latency is 1 cycle.
//   - rsp_rdata is driven through the bank mux from the SPRAM DATAOUT pins.
// TESTING
//  - Write 0xBEEF @0x0005, then read @0x0005.
//    -> rsp_valid 1 cycle after acceptance (2 with SPRAM_OUTREG_EN), rsp_rdata=0xBEEF.
//  - BANKS=4: write 0xABCD @0x0000 and 0x1234 @0x4000, then read both.
//    -> 0xABCD, 0x1234; no cross-bank aliasing.
//  - Write 0xFFFF @0x10, write 0x0000 @0x10 with req_mask=4'b0011, read @0x10.
//    -> 0xFF00.
//  - Reads @0..7 on consecutive cycles.
//    -> 8 consecutive rsp_valid pulses, data in address order.
//  - IDLE_CYCLES=8, WAKE_CYCLES=3: 8 idle cycles.
//    -> sleeping=1, req_ready=0.
//    Then hold a read request.
//    -> req_ready=1 after 3 WAKE cycles; data read back is unchanged.
//  - Assert rst_n=0 in the cycle after a read is accepted.
//    -> rsp_valid stays 0; req_ready=1 after release.

Source files
------------

// File: rtl/spram_banked.sv
// 1/2/4-bank 16-bit SPRAM word store with valid/ready requests, nibble write masks and idle SLEEP/WAKE.
// Define SPRAM_OUTREG_EN to register the read data after the bank mux (2-cycle read latency).
module spram_banked #(
  parameter  int BANKS       = 1,
  parameter  int IDLE_CYCLES = 0,
  parameter  int WAKE_CYCLES = 3,
  localparam int ADDR_W      = 14 + $clog2(BANKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  input  logic [3:0]        req_mask,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              sleeping
);
  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
`ifdef SPRAM_OUTREG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif
  // SPRAM pin tie-offs: always powered, never in standby
  localparam logic POWEROFF = 1'b1;
  localparam logic STANDBY  = 1'b0;

  typedef enum logic [1:0] {ST_ACTIVE, ST_SLEEP, ST_WAKE} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idle_q, idle_d;
  logic [WW-1:0]       wake_q, wake_d;
  logic [STAGES:1]     vld_pipe_q, vld_pipe_d;
  logic                accept, rd_acc, bank_sleep;
  logic [BW-1:0]       bank_idx;
  logic [BANKS-1:0][15:0] bank_dout;
  logic [15:0]         mux_dout;

  assign req_ready  = (state_q == ST_ACTIVE);
  assign sleeping   = (state_q != ST_ACTIVE);
  assign bank_sleep = (state_q == ST_SLEEP);
  assign accept     = req_valid && req_ready;
  assign rd_acc     = accept && !req_we;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [15:0] mem [16384];
    logic [15:0] dout_q;
    logic        cs;
    assign cs = accept && (bank_idx == BW'(b));
    // Behavioural SB_SPRAM256KA: DATAOUT updates only on reads and holds otherwise
    always_ff @(posedge clk) begin
      if (cs && !bank_sleep && !STANDBY && POWEROFF) begin
        if (req_we) begin
          for (int n = 0; n < 4; n++)
            if (req_mask[n]) mem[req_addr[13:0]][4*n +: 4] <= req_wdata[4*n +: 4];
        end else begin
          dout_q <= mem[req_addr[13:0]];
        end
      end
    end
    assign bank_dout[b] = dout_q;
  end

  if (BANKS > 1) begin : g_sel
    logic [BW-1:0] bank_sel_q, bank_sel_d;
    assign bank_idx = req_addr[ADDR_W-1 -: BW];
    always_comb begin
      bank_sel_d = bank_sel_q;
      if (rd_acc) bank_sel_d = bank_idx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bank_sel_q <= '0;
      else        bank_sel_q <= bank_sel_d;
    end
    assign mux_dout = bank_dout[bank_sel_q];
  end else begin : g_nosel
    assign bank_idx = 1'b0;
    assign mux_dout = bank_dout[0];
  end

`ifdef SPRAM_OUTREG_EN
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  always_comb begin
    vld_pipe_d  = {vld_pipe_q[1], rd_acc};
    rsp_rdata_d = vld_pipe_q[1] ? mux_dout : rsp_rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_rdata_q <= '0;
    else        rsp_rdata_q <= rsp_rdata_d;
  end
  assign rsp_rdata = rsp_rdata_q;
`else
  // Banks have no reset, so mask their output until a read has been accepted
  logic rd_seen_q, rd_seen_d;
  always_comb begin
    vld_pipe_d = rd_acc;
    rd_seen_d  = rd_seen_q | rd_acc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_seen_q <= 1'b0;
    else        rd_seen_q <= rd_seen_d;
  end
  assign rsp_rdata = rd_seen_q ? mux_dout : 16'h0000;
`endif
  assign rsp_valid = vld_pipe_q[STAGES];

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    case (state_q)
      ST_ACTIVE: begin
        if (accept) begin
          idle_d = '0;
        end else if (IDLE_CYCLES != 0) begin
          if (idle_q != IW'(IDLE_CYCLES)) idle_d = idle_q + 1'b1;
          // Saturate and wait for any in-flight read response to drain
          if (idle_d == IW'(IDLE_CYCLES) && !(|vld_pipe_q)) begin
            state_d = ST_SLEEP;
            idle_d  = '0;
          end
        end
      end
      ST_SLEEP: begin
        if (req_valid) begin
          state_d = ST_WAKE;
          wake_d  = '0;
        end
      end
      ST_WAKE: begin
        if (wake_q == WW'(WAKE_CYCLES - 1)) begin
          state_d = ST_ACTIVE;
          wake_d  = '0;
        end else begin
          wake_d = wake_q + 1'b1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACTIVE;
      idle_q     <= '0;
      wake_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_q     <= idle_d;
      wake_q     <= wake_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end
endmodule

// File: tb/tb_spram_banked.sv
// Directed bench for spram_banked: 4 banks, IDLE_CYCLES=8, WAKE_CYCLES=3.
module tb_spram_banked;
`ifdef SPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_mask = 4'hF;
  logic        rsp_valid, sleeping;
  logic [15:0] rsp_rdata;
  int checks = 0;
  int errors = 0;

  spram_banked #(.BANKS(4), .IDLE_CYCLES(8), .WAKE_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .sleeping(sleeping));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wd, input logic [3:0] m);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_mask = m;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready) begin errors++; $display("FAIL issue_ready got %0b want 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic read_chk(input logic [15:0] addr, input logic [15:0] exp, input string name);
    issue(1'b0, addr, 16'h0, 4'hF);
    if (LAT == 2) begin
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s early_valid got %0b want 0", name, rsp_valid); end
      @(negedge clk);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
      errors++; $display("FAIL %s got valid=%0b data=%h want valid=1 data=%h", name, rsp_valid, rsp_rdata, exp);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || sleeping !== 1'b0) begin
      errors++; $display("FAIL reset got ready=%0b valid=%0b data=%h sleep=%0b want 1 0 0000 0",
                         req_ready, rsp_valid, rsp_rdata, sleeping);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    issue(1'b1, 16'h0005, 16'hBEEF, 4'hF);
    read_chk(16'h0005, 16'hBEEF, "basic_read");
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %0b want 0", rsp_valid); end
    checks++;
    if (rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL basic_hold got %h want beef", rsp_rdata); end
  endtask

  task automatic test_banks;
    issue(1'b1, 16'h0000, 16'hABCD, 4'hF);
    issue(1'b1, 16'h4000, 16'h1234, 4'hF);
    issue(1'b1, 16'hC000, 16'h7777, 4'hF);
    read_chk(16'h0000, 16'hABCD, "bank0");
    read_chk(16'h4000, 16'h1234, "bank1");
    read_chk(16'hC000, 16'h7777, "bank3");
  endtask

  task automatic test_mask;
    issue(1'b1, 16'h0010, 16'hFFFF, 4'hF);
    issue(1'b1, 16'h0010, 16'h0000, 4'b0011);
    read_chk(16'h0010, 16'hFF00, "mask_lo");
    issue(1'b1, 16'h0010, 16'h0A00, 4'b0100);
    read_chk(16'h0010, 16'hFA00, "mask_n2");
  endtask

  task automatic test_back_to_back;
    logic [15:0] vals [8];
    for (int i = 0; i < 8; i++) begin
      vals[i] = 16'h1000 + 16'(i) * 16'h0111;
      issue(1'b1, 16'(i), vals[i], 4'hF);
    end
    for (int k = 0; k < 8 + LAT; k++) begin
      if (k < 8) begin req_valid = 1'b1; req_we = 1'b0; req_addr = 16'(k); end
      else req_valid = 1'b0;
      if (k >= LAT) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== vals[k-LAT]) begin
          errors++; $display("FAIL b2b_%0d got valid=%0b data=%h want valid=1 data=%h",
                             k - LAT, rsp_valid, rsp_rdata, vals[k-LAT]);
        end
      end
      @(negedge clk);
    end
    // read immediately followed by a write to the same word
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
    @(negedge clk);
    req_we = 1'b1; req_wdata = 16'h5A5A; req_mask = 4'hF;
    if (LAT == 1) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hFA00) begin
        errors++; $display("FAIL rd_then_wr got valid=%0b data=%h want 1 fa00", rsp_valid, rsp_rdata);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (LAT == 2) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hFA00) begin
        errors++; $display("FAIL rd_then_wr got valid=%0b data=%h want 1 fa00", rsp_valid, rsp_rdata);
      end
    end
    read_chk(16'h0010, 16'h5A5A, "wr_after_rd");
  endtask

  task automatic test_sleep;
    issue(1'b1, 16'h0100, 16'h0F0F, 4'hF);
    repeat (7) @(negedge clk);
    checks++;
    if (sleeping !== 1'b0) begin errors++; $display("FAIL idle7 sleeping got %0b want 0", sleeping); end
    @(negedge clk);
    checks++;
    if (sleeping !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL idle8 got sleep=%0b ready=%0b want 1 0", sleeping, req_ready);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || sleeping !== 1'b1) begin
        errors++; $display("FAIL wake_%0d got ready=%0b sleep=%0b want 0 1", i, req_ready, sleeping);
      end
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || sleeping !== 1'b0) begin
      errors++; $display("FAIL awake got ready=%0b sleep=%0b want 1 0", req_ready, sleeping);
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (LAT == 2) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234) begin
      errors++; $display("FAIL retained got valid=%0b data=%h want 1 1234", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid_read;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0005;
    @(posedge clk);
    #1 rst_n = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_%0d valid got %0b want 0", i, rsp_valid); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 16'h0) begin
      errors++; $display("FAIL rst_release got ready=%0b valid=%0b data=%h want 1 0 0000",
                         req_ready, rsp_valid, rsp_rdata);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_banks;
    test_mask;
    test_back_to_back;
    test_sleep;
    test_reset_mid_read;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
